// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logical/arithmetic/rotate barrel shifter with valid/ready flow control.
// Stage k applies the 2^k step, so the output is taken straight from the last stage register.
module pipelined_barrel_shifter #(
  parameter  int unsigned WIDTH = 8,
  localparam int          AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] num,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  input  logic [1:0]       mode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] shiftedNum,
  output logic             outZero
);

  localparam int Last = AMT_W - 1;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input int unsigned      sh,
    input logic             right,
    input logic [1:0]       op,
    input logic             sign
  );
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> sh);  // ones in the top sh positions vacated by a right shift
    case (op)
      2'b00:   shift_step = right ? (d >> sh) : (d << sh);
      2'b01:   shift_step = right ? ((d >> sh) | (sign ? fill : '0)) : (d << sh);
      2'b10:   shift_step = right ? ((d >> sh) | (d << (WIDTH - sh)))
                                  : ((d << sh) | (d >> (WIDTH - sh)));
      default: shift_step = '0;
    endcase
  endfunction

  logic [AMT_W-1:0] stage_valid;
  logic [AMT_W-1:0] stage_rdy;
  logic             en_q;

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic room;
    room = outReady;
    for (int k = AMT_W - 1; k >= 0; k--) begin
      room         = room | ~stage_valid[k];
      stage_rdy[k] = room;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  assign inReady = en_q & stage_rdy[0];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    logic                 src_valid;
    logic [WIDTH-1:0]     src_data;
    logic                 src_lr;
    logic [1:0]           src_mode;
    logic                 src_sign;
    logic [AMT_W-1-k:0]   src_amt;
    logic [WIDTH-1:0]     step_data;
    logic                 valid_q;
    logic [WIDTH-1:0]     data_q;

    if (k == 0) begin : g_src
      assign src_valid = inValid & inReady;
      assign src_data  = num;
      assign src_lr    = lr;
      assign src_mode  = mode;
      assign src_sign  = num[WIDTH-1];
      assign src_amt   = amt;
    end else begin : g_src
      assign src_valid = g_stage[k-1].valid_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_lr    = g_stage[k-1].g_carry.lr_q;
      assign src_mode  = g_stage[k-1].g_carry.mode_q;
      assign src_sign  = g_stage[k-1].g_carry.sign_q;
      assign src_amt   = g_stage[k-1].g_carry.amt_q;
    end

    always_comb begin
      step_data = src_data;
      if (src_mode == 2'b11) begin
        step_data = '0;
      end else if (src_amt[0]) begin
        step_data = shift_step(src_data, 1 << k, src_lr, src_mode, src_sign);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (stage_rdy[k]) begin
        valid_q <= src_valid;
        if (src_valid) begin
          data_q <= step_data;
        end
      end
    end

    assign stage_valid[k] = valid_q;

    // Control fields travel with the data only as far as a later stage still needs them.
    if (k < Last) begin : g_carry
      logic [AMT_W-2-k:0] amt_q;
      logic               lr_q;
      logic [1:0]         mode_q;
      logic               sign_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q  <= '0;
          lr_q   <= 1'b0;
          mode_q <= 2'b00;
          sign_q <= 1'b0;
        end else if (stage_rdy[k] && src_valid) begin
          amt_q  <= src_amt[AMT_W-1-k:1];
          lr_q   <= src_lr;
          mode_q <= src_mode;
          sign_q <= src_sign;
        end
      end
    end
  end

  assign outValid   = g_stage[Last].valid_q;
  assign shiftedNum = g_stage[Last].data_q;
  assign outZero    = outValid & ~|shiftedNum;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (WIDTH=8): directed vectors, back-pressure, random traffic
// and mid-flight reset, all checked in order against a plain arithmetic reference model.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [W-1:0]  num = '0;
  logic [AW-1:0] amt = '0;
  logic          lr = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [W-1:0]  shiftedNum;
  logic          outZero;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit check_lat = 1'b0;
  bit front_seen = 1'b0;
  bit hold = 1'b0;
  bit saw_block = 1'b0;
  bit rand_done = 1'b0;
  logic [W-1:0] hold_data;

  typedef struct {
    logic [W-1:0] res;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [7:0] n;
    logic [2:0] a;
    logic       d;
    logic [1:0] m;
    logic [7:0] r;
  } vec_t;

  vec_t vecs [NV] = '{
    '{8'h01, 3'd3, 1'b0, 2'b00, 8'h08},
    '{8'hE2, 3'd6, 1'b0, 2'b00, 8'h80},
    '{8'h00, 3'd0, 1'b0, 2'b00, 8'h00},
    '{8'h80, 3'd3, 1'b1, 2'b01, 8'hF0},
    '{8'h80, 3'd7, 1'b1, 2'b01, 8'hFF},
    '{8'h44, 3'd7, 1'b1, 2'b01, 8'h00},
    '{8'hF0, 3'd1, 1'b1, 2'b01, 8'hF8},
    '{8'hF0, 3'd1, 1'b1, 2'b00, 8'h78},
    '{8'h81, 3'd1, 1'b1, 2'b10, 8'hC0},
    '{8'hE2, 3'd6, 1'b0, 2'b10, 8'hB8},
    '{8'h07, 3'd7, 1'b0, 2'b10, 8'h83},
    '{8'hFF, 3'd3, 1'b0, 2'b11, 8'h00},
    '{8'h81, 3'd1, 1'b0, 2'b01, 8'h02},
    '{8'h5A, 3'd0, 1'b1, 2'b10, 8'h5A}
  };

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .inReady   (inReady),
    .num       (num),
    .amt       (amt),
    .lr        (lr),
    .mode      (mode),
    .outValid  (outValid),
    .outReady  (outReady),
    .shiftedNum(shiftedNum),
    .outZero   (outZero)
  );

  function automatic logic [W-1:0] ref_shift(logic [W-1:0] n, int a, logic right, logic [1:0] m);
    logic [W-1:0]        r;
    logic signed [W-1:0] s;
    r = '0;
    s = n;
    if (m == 2'b11) begin
      r = '0;
    end else if (m == 2'b10) begin
      for (int i = 0; i < W; i++) begin
        if (right) r[i] = n[(i + a) % W];
        else       r[(i + a) % W] = n[i];
      end
    end else if (m == 2'b01 && right) begin
      s = s >>> a;
      r = s;
    end else if (right) begin
      r = n >> a;
    end else begin
      r = n << a;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Single compare process: every negedge, outputs against the in-order expectation queue.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      hold = 1'b0;
      front_seen = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid_stable", outValid, 1);
        check("stall_data_stable", shiftedNum, hold_data);
      end
      if (outValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", outValid, 0);
        end else begin
          check("result", shiftedNum, exp_q[0].res);
          check("zero_flag", outZero, exp_q[0].res == '0);
          if (check_lat && !front_seen) check("latency", cyc - exp_q[0].acc, 3);
          front_seen = 1'b1;
          if (outReady) begin
            void'(exp_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      hold      = outValid && !outReady;
      hold_data = shiftedNum;
      if (outValid && !outReady && !inReady) saw_block = 1'b1;
      if (inValid && inReady) exp_q.push_back('{ref_shift(num, int'(amt), lr, mode), cyc});
    end
  end

  task automatic send(input logic [W-1:0] n, input int a, input logic d, input logic [1:0] m);
    int budget;
    budget  = 0;
    inValid = 1'b1;
    num     = n;
    amt     = a[AW-1:0];
    lr      = d;
    mode    = m;
    do begin
      @(negedge clk);
      budget++;
    end while (!inReady && budget < 200);
    if (!inReady) check("send_timeout", inReady, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inValid = 1'b0;
    num     = W'($urandom);
    amt     = AW'($urandom);
    lr      = 1'($urandom);
    mode    = 2'($urandom);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget   = 0;
    outReady = 1'b1;
    while ((exp_q.size() != 0 || outValid) && budget < 200) begin
      wait_cycles(1);
      budget++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2;
    check("reset_outValid", outValid, 0);
    check("reset_shiftedNum", shiftedNum, 0);
    check("reset_outZero", outZero, 0);
    check("reset_inReady", inReady, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", inReady, 1);

    // Pin the model to hand-computed values, then run each vector alone.
    check_lat = 1'b1;
    for (int i = 0; i < NV; i++) begin
      check($sformatf("model_vec%0d", i),
            ref_shift(vecs[i].n, int'(vecs[i].a), vecs[i].d, vecs[i].m), vecs[i].r);
      send(vecs[i].n, int'(vecs[i].a), vecs[i].d, vecs[i].m);
      idle();
      wait_cycles(4);
    end

    // Same vectors back to back: full throughput, fixed latency.
    for (int i = 0; i < NV; i++) send(vecs[i].n, int'(vecs[i].a), vecs[i].d, vecs[i].m);
    idle();
    drain();

    // Back-pressure: 8 back-to-back sends, consumer stalls for cycles 4-7.
    check_lat = 1'b0;
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom),
                                         2'($urandom));
        idle();
      end
      begin
        for (int c = 0; c < 12; c++) begin
          outReady = !(c >= 4 && c < 8);
          wait_cycles(1);
        end
        outReady = 1'b1;
      end
    join
    drain();
    check("inReady_dropped_when_full", saw_block, 1);

    // Random traffic with random producer gaps and consumer stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            wait_cycles(1);
          end
          send(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom), 2'($urandom));
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          outReady = ($urandom_range(0, 3) != 0);
          wait_cycles(1);
        end
      end
    join
    drain();

    // Reset with two transactions in flight.
    check_lat = 1'b1;
    send(8'hA5, 2, 1'b0, 2'b00);
    send(8'h3C, 1, 1'b1, 2'b10);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outValid", outValid, 0);
    check("midreset_shiftedNum", shiftedNum, 0);
    check("midreset_outZero", outZero, 0);
    check("midreset_inReady", inReady, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midreset", inReady, 1);
    wait_cycles(6);
    send(8'h01, 3, 1'b0, 2'b00);
    idle();
    wait_cycles(5);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
